// File: rtl/dmem_responder_if.sv
// Request/response bus between the load/store unit and dmem_responder.
//
// Handshake rules (both channels): a transfer happens on a rising clock edge
// where valid and ready are both 1. The valid side must hold valid and its
// payload stable until that edge; ready may change freely. On the request
// channel the initiator drives valid, the responder drives ready. On the
// response channel the responder drives valid, the initiator drives ready.
interface dmem_responder_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  // request channel
  logic                  i_req_valid;
  logic                  o_req_ready;
  logic                  i_req_we;
  logic [ADDR_WIDTH-1:0] i_req_addr;
  logic [DATA_WIDTH-1:0] i_req_wdata;
  logic [2:0]            i_req_funct3;
  // response channel
  logic                  o_rsp_valid;
  logic                  i_rsp_ready;
  logic [DATA_WIDTH-1:0] o_rsp_rdata;
  logic                  o_rsp_err;

  // load/store unit side
  modport master (
    output i_req_valid, i_req_we, i_req_addr, i_req_wdata, i_req_funct3,
    output i_rsp_ready,
    input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err
  );

  // memory side
  modport slave (
    input  i_req_valid, i_req_we, i_req_addr, i_req_wdata, i_req_funct3,
    input  i_rsp_ready,
    output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Memory-side responder for the load/store unit.
// Accepts one load/store at a time, performs it on a word-organised RAM with
// byte/halfword lanes, sign/zero extension and misalignment checks, and
// returns the result over the response channel. All outputs are registered.
//
// Optional feature macro: DMEM_WAIT_STATES_EN
//   defined   -> a WAIT state and down-counter stretch every access by
//                WAIT_CYCLES cycles (DDR3 latency emulation).
//   undefined -> fixed 2-cycle latency, WAIT_CYCLES is ignored.
//
// dbg_state_o exposes the FSM state: 0 IDLE, 1 ACCESS, 2 RESP, 3 WAIT.
module dmem_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_DEPTH   = 32,
  parameter int WAIT_CYCLES = 4
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  dmem_responder_if.slave     bus,
  output logic [1:0]          dbg_state_o
);

  localparam int IDX_W = $clog2(MEM_DEPTH);

  // funct3 encodings
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

`ifdef DMEM_WAIT_STATES_EN
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2,
    S_WAIT   = 2'd3
  } state_t;
  // counter must be at least one bit wide even when WAIT_CYCLES is 0
  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;
`endif

  state_t state_q, state_d;

  // registered outputs
  logic                  req_ready_q, req_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q,   rsp_err_d;

  // request fields captured on the request handshake
  logic                  we_q,     we_d;
  logic [IDX_W-1:0]      idx_q,    idx_d;
  logic [1:0]            off_q,    off_d;
  logic [DATA_WIDTH-1:0] wdata_q,  wdata_d;
  logic [2:0]            funct3_q, funct3_d;

  // data RAM, deliberately not cleared by reset
  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  // access decode, all derived from the captured request
  logic                  acc_err;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [7:0]            rd_byte;
  logic [15:0]           rd_half;
  logic [DATA_WIDTH-1:0] load_val;
  logic [3:0]            wr_be;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  mem_we;
  logic                  req_hs;

  // Upper address bits alias onto the RAM and are intentionally dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.i_req_addr[ADDR_WIDTH-1:IDX_W+2];

  assign req_hs = bus.i_req_valid && req_ready_q;

  // Legality of the captured access: encoding, direction and alignment.
  always_comb begin
    acc_err = 1'b0;
    case (funct3_q)
      F3_B:    acc_err = 1'b0;
      F3_H:    acc_err = off_q[0];
      F3_W:    acc_err = (off_q != 2'b00);
      F3_BU:   acc_err = we_q;
      F3_HU:   acc_err = we_q || off_q[0];
      default: acc_err = 1'b1;
    endcase
  end

  // Load path: pick the addressed lane(s) and extend to a full word.
  always_comb begin
    rd_word  = mem_q[idx_q];
    rd_byte  = rd_word[{off_q, 3'b000} +: 8];
    rd_half  = off_q[1] ? rd_word[31:16] : rd_word[15:0];
    load_val = '0;
    case (funct3_q)
      F3_B:    load_val = {{24{rd_byte[7]}}, rd_byte};
      F3_H:    load_val = {{16{rd_half[15]}}, rd_half};
      F3_W:    load_val = rd_word;
      F3_BU:   load_val = {24'h0, rd_byte};
      F3_HU:   load_val = {16'h0, rd_half};
      default: load_val = '0;
    endcase
  end

  // Store path: replicate right-aligned data across lanes, enable only the
  // addressed ones so the other lanes keep their contents.
  always_comb begin
    wr_be   = 4'b0000;
    wr_data = wdata_q;
    case (funct3_q)
      F3_B: begin
        wr_be   = 4'b0001 << off_q;
        wr_data = {4{wdata_q[7:0]}};
      end
      F3_H: begin
        wr_be   = off_q[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{wdata_q[15:0]}};
      end
      F3_W: begin
        wr_be   = 4'b1111;
        wr_data = wdata_q;
      end
      default: begin
        wr_be   = 4'b0000;
        wr_data = wdata_q;
      end
    endcase
  end

  // A store commits at the end of ACCESS only if reset is not asserted on
  // that same edge.
  assign mem_we = (state_q == S_ACCESS) && we_q && !acc_err && i_reset_n;

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    we_d        = we_q;
    idx_d       = idx_q;
    off_d       = off_q;
    wdata_d     = wdata_q;
    funct3_d    = funct3_q;
`ifdef DMEM_WAIT_STATES_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        req_ready_d = 1'b1;
        if (req_hs) begin
          req_ready_d = 1'b0;
          we_d        = bus.i_req_we;
          idx_d       = bus.i_req_addr[IDX_W+1:2];
          off_d       = bus.i_req_addr[1:0];
          wdata_d     = bus.i_req_wdata;
          funct3_d    = bus.i_req_funct3;
`ifdef DMEM_WAIT_STATES_EN
          if (WAIT_CYCLES > 0) begin
            state_d = S_WAIT;
            cnt_d   = CNT_W'(WAIT_CYCLES);
          end else begin
            state_d = S_ACCESS;
          end
`else
          state_d = S_ACCESS;
`endif
        end
      end
`ifdef DMEM_WAIT_STATES_EN
      S_WAIT: begin
        // counter holds the number of WAIT cycles still to spend, this one
        // included
        if (cnt_q <= CNT_W'(1)) begin
          state_d = S_ACCESS;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`endif
      S_ACCESS: begin
        state_d     = S_RESP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = acc_err;
        rsp_rdata_d = (acc_err || we_q) ? '0 : load_val;
      end
      S_RESP: begin
        if (bus.i_rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
          req_ready_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, output and captured-request registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q     <= S_IDLE;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      we_q        <= 1'b0;
      idx_q       <= '0;
      off_q       <= '0;
      wdata_q     <= '0;
      funct3_q    <= '0;
`ifdef DMEM_WAIT_STATES_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      we_q        <= we_d;
      idx_q       <= idx_d;
      off_q       <= off_d;
      wdata_q     <= wdata_d;
      funct3_q    <= funct3_d;
`ifdef DMEM_WAIT_STATES_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  // RAM write port with per-lane enables.
  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem_q[idx_q][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  assign bus.o_req_ready = req_ready_q;
  assign bus.o_rsp_valid = rsp_valid_q;
  assign bus.o_rsp_rdata = rsp_rdata_q;
  assign bus.o_rsp_err   = rsp_err_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder.
// Works with or without DMEM_WAIT_STATES_EN; the expected response latency
// follows the macro.
module tb_dmem_responder;

  localparam int WAIT_CYCLES = 4;
`ifdef DMEM_WAIT_STATES_EN
  localparam int EXP_LAT = WAIT_CYCLES + 2;
`else
  localparam int EXP_LAT = 2;
`endif

  // ---------------- clock / reset ----------------
  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  dmem_responder_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  dmem_responder #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .MEM_DEPTH  (32),
    .WAIT_CYCLES(WAIT_CYCLES)
  ) dut (
    .i_clk      (clk),
    .i_reset_n  (rst_n),
    .bus        (bus),
    .dbg_state_o(dbg_state)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- driver ----------------
  // Waits for o_req_ready, performs one request, waits for the response,
  // completes the response handshake and returns at the falling edge of the
  // cycle after that handshake. lat counts falling edges from the request
  // handshake until o_rsp_valid is seen (2 means valid from cycle c+2).
  task automatic do_txn(input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] f3,
                        output logic [31:0] rdata, output logic err,
                        output int lat);
    int n;
    rdata = '0; err = 1'b0; lat = 0; n = 0;
    while (bus.o_req_ready !== 1'b1 && n < 50) begin
      @(negedge clk); n++;
    end
    if (bus.o_req_ready !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL req_ready_timeout addr=%h got=%b required=1", addr, bus.o_req_ready);
      lat = -1;
    end else begin
      bus.i_req_valid  = 1'b1;
      bus.i_req_we     = we;
      bus.i_req_addr   = addr;
      bus.i_req_wdata  = wdata;
      bus.i_req_funct3 = f3;
      @(posedge clk);
      #1;
      // scramble the fields: the responder must use the captured copy
      bus.i_req_valid  = 1'b0;
      bus.i_req_we     = ~we;
      bus.i_req_addr   = 32'hFFFF_FFFF;
      bus.i_req_wdata  = ~wdata;
      bus.i_req_funct3 = 3'b111;
      do begin
        @(negedge clk); lat++;
      end while (bus.o_rsp_valid !== 1'b1 && lat < 50);
      if (bus.o_rsp_valid !== 1'b1) begin
        n_cmp++; n_bad++;
        $display("FAIL rsp_valid_timeout addr=%h got=%b required=1", addr, bus.o_rsp_valid);
        lat = -1;
      end else begin
        rdata = bus.o_rsp_rdata;
        err   = bus.o_rsp_err;
        bus.i_rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.i_rsp_ready = 1'b0;
        @(negedge clk);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    bus.i_req_valid = 1'b0; bus.i_req_we = 1'b0; bus.i_req_addr = '0;
    bus.i_req_wdata = '0; bus.i_req_funct3 = 3'b010; bus.i_rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.o_req_ready !== 1'b0) begin n_bad++; $display("FAIL rst_req_ready got=%b required=0", bus.o_req_ready); end
    n_cmp++; if (bus.o_rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_rsp_valid got=%b required=0", bus.o_rsp_valid); end
    n_cmp++; if (bus.o_rsp_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_rsp_rdata got=%h required=0", bus.o_rsp_rdata); end
    n_cmp++; if (bus.o_rsp_err !== 1'b0) begin n_bad++; $display("FAIL rst_rsp_err got=%b required=0", bus.o_rsp_err); end
    n_cmp++; if (dbg_state !== 2'd0) begin n_bad++; $display("FAIL rst_state got=%0d required=0", dbg_state); end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.o_req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready_rise got=%b required=1", bus.o_req_ready); end
  endtask

  task automatic test_word_roundtrip();
    logic [31:0] rd; logic er; int lt;
    do_txn(1'b1, 32'h08, 32'hDEADBEEF, 3'b010, rd, er, lt);
    n_cmp++; if (rd !== 32'h0 || er !== 1'b0) begin n_bad++; $display("FAIL sw08 got=%h/%b required=0/0", rd, er); end
    n_cmp++; if (lt != EXP_LAT) begin n_bad++; $display("FAIL sw08_latency got=%0d required=%0d", lt, EXP_LAT); end
    n_cmp++; if (bus.o_req_ready !== 1'b1 || bus.o_rsp_valid !== 1'b0) begin n_bad++; $display("FAIL post_rsp_hs got ready=%b valid=%b required 1/0", bus.o_req_ready, bus.o_rsp_valid); end
    do_txn(1'b0, 32'h08, 32'h0, 3'b010, rd, er, lt);
    n_cmp++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin n_bad++; $display("FAIL lw08 got=%h/%b required=deadbeef/0", rd, er); end
    n_cmp++; if (lt != EXP_LAT) begin n_bad++; $display("FAIL lw08_latency got=%0d required=%0d", lt, EXP_LAT); end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd; logic er; int lt;
    do_txn(1'b1, 32'h09, 32'hFFFFFF7F, 3'b000, rd, er, lt);
    n_cmp++; if (rd !== 32'h0 || er !== 1'b0) begin n_bad++; $display("FAIL sb09 got=%h/%b required=0/0", rd, er); end
    do_txn(1'b0, 32'h08, 32'h0, 3'b010, rd, er, lt);
    n_cmp++; if (rd !== 32'hDEAD7FEF || er !== 1'b0) begin n_bad++; $display("FAIL lw08_after_sb got=%h/%b required=dead7fef/0", rd, er); end
    do_txn(1'b0, 32'h0B, 32'h0, 3'b000, rd, er, lt);
    n_cmp++; if (rd !== 32'hFFFFFFDE || er !== 1'b0) begin n_bad++; $display("FAIL lb0b got=%h/%b required=ffffffde/0", rd, er); end
    do_txn(1'b0, 32'h0B, 32'h0, 3'b100, rd, er, lt);
    n_cmp++; if (rd !== 32'h000000DE || er !== 1'b0) begin n_bad++; $display("FAIL lbu0b got=%h/%b required=000000de/0", rd, er); end
    do_txn(1'b0, 32'h0A, 32'h0, 3'b001, rd, er, lt);
    n_cmp++; if (rd !== 32'hFFFFDEAD || er !== 1'b0) begin n_bad++; $display("FAIL lh0a got=%h/%b required=ffffdead/0", rd, er); end
    do_txn(1'b0, 32'h08, 32'h0, 3'b101, rd, er, lt);
    n_cmp++; if (rd !== 32'h00007FEF || er !== 1'b0) begin n_bad++; $display("FAIL lhu08 got=%h/%b required=00007fef/0", rd, er); end
    do_txn(1'b0, 32'h09, 32'h0, 3'b000, rd, er, lt);
    n_cmp++; if (rd !== 32'h0000007F || er !== 1'b0) begin n_bad++; $display("FAIL lb09 got=%h/%b required=0000007f/0", rd, er); end
    // upper halfword store into a fresh word
    do_txn(1'b1, 32'h10, 32'h11223344, 3'b010, rd, er, lt);
    do_txn(1'b1, 32'h12, 32'hABCD5678, 3'b001, rd, er, lt);
    n_cmp++; if (rd !== 32'h0 || er !== 1'b0) begin n_bad++; $display("FAIL sh12 got=%h/%b required=0/0", rd, er); end
    do_txn(1'b0, 32'h10, 32'h0, 3'b010, rd, er, lt);
    n_cmp++; if (rd !== 32'h56783344 || er !== 1'b0) begin n_bad++; $display("FAIL lw10_after_sh got=%h/%b required=56783344/0", rd, er); end
    do_txn(1'b0, 32'h10, 32'h0, 3'b001, rd, er, lt);
    n_cmp++; if (rd !== 32'h00003344 || er !== 1'b0) begin n_bad++; $display("FAIL lh10 got=%h/%b required=00003344/0", rd, er); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lt;
    do_txn(1'b0, 32'h0A, 32'h0, 3'b010, rd, er, lt);
    n_cmp++; if (rd !== 32'h0 || er !== 1'b1) begin n_bad++; $display("FAIL lw0a_misaligned got=%h/%b required=0/1", rd, er); end
    n_cmp++; if (lt != EXP_LAT) begin n_bad++; $display("FAIL err_latency got=%0d required=%0d", lt, EXP_LAT); end
    do_txn(1'b1, 32'h09, 32'h0000FFFF, 3'b001, rd, er, lt);
    n_cmp++; if (rd !== 32'h0 || er !== 1'b1) begin n_bad++; $display("FAIL sh09_misaligned got=%h/%b required=0/1", rd, er); end
    do_txn(1'b0, 32'h08, 32'h0, 3'b011, rd, er, lt);
    n_cmp++; if (rd !== 32'h0 || er !== 1'b1) begin n_bad++; $display("FAIL f3_011 got=%h/%b required=0/1", rd, er); end
    do_txn(1'b1, 32'h08, 32'h00000055, 3'b100, rd, er, lt);
    n_cmp++; if (rd !== 32'h0 || er !== 1'b1) begin n_bad++; $display("FAIL sbu_illegal got=%h/%b required=0/1", rd, er); end
    do_txn(1'b0, 32'h09, 32'h0, 3'b101, rd, er, lt);
    n_cmp++; if (rd !== 32'h0 || er !== 1'b1) begin n_bad++; $display("FAIL lhu09_misaligned got=%h/%b required=0/1", rd, er); end
    do_txn(1'b0, 32'h08, 32'h0, 3'b110, rd, er, lt);
    n_cmp++; if (rd !== 32'h0 || er !== 1'b1) begin n_bad++; $display("FAIL f3_110 got=%h/%b required=0/1", rd, er); end
    do_txn(1'b0, 32'h08, 32'h0, 3'b010, rd, er, lt);
    n_cmp++; if (rd !== 32'hDEAD7FEF || er !== 1'b0) begin n_bad++; $display("FAIL lw08_unchanged got=%h/%b required=dead7fef/0", rd, er); end
  endtask

  task automatic test_backpressure();
    int n; int lt;
    n = 0;
    while (bus.o_req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    bus.i_req_valid = 1'b1; bus.i_req_we = 1'b0; bus.i_req_addr = 32'h08;
    bus.i_req_wdata = 32'h0; bus.i_req_funct3 = 3'b010;
    @(posedge clk);
    #1;
    bus.i_req_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (bus.o_rsp_valid !== 1'b1 && n < 50);
    n_cmp++; if (bus.o_rsp_valid !== 1'b1) begin n_bad++; $display("FAIL bp_rsp_timeout got=%b required=1", bus.o_rsp_valid); end
    // second request presented while the first response is held
    bus.i_req_valid = 1'b1; bus.i_req_we = 1'b0; bus.i_req_addr = 32'h10;
    bus.i_req_funct3 = 3'b010;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++; if (bus.o_rsp_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid[%0d] got=%b required=1", i, bus.o_rsp_valid); end
      n_cmp++; if (bus.o_rsp_rdata !== 32'hDEAD7FEF) begin n_bad++; $display("FAIL bp_rdata[%0d] got=%h required=dead7fef", i, bus.o_rsp_rdata); end
      n_cmp++; if (bus.o_rsp_err !== 1'b0) begin n_bad++; $display("FAIL bp_err[%0d] got=%b required=0", i, bus.o_rsp_err); end
      n_cmp++; if (bus.o_req_ready !== 1'b0) begin n_bad++; $display("FAIL bp_req_ready[%0d] got=%b required=0", i, bus.o_req_ready); end
    end
    bus.i_rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.i_rsp_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.o_req_ready !== 1'b1 || bus.o_rsp_valid !== 1'b0) begin n_bad++; $display("FAIL bp_release got ready=%b valid=%b required 1/0", bus.o_req_ready, bus.o_rsp_valid); end
    @(posedge clk);
    #1;
    bus.i_req_valid = 1'b0; bus.i_req_addr = 32'hFFFF_FFFF; bus.i_req_funct3 = 3'b111;
    lt = 0;
    do begin @(negedge clk); lt++; end while (bus.o_rsp_valid !== 1'b1 && lt < 50);
    n_cmp++; if (lt != EXP_LAT) begin n_bad++; $display("FAIL bp_second_latency got=%0d required=%0d", lt, EXP_LAT); end
    n_cmp++; if (bus.o_rsp_rdata !== 32'h56783344 || bus.o_rsp_err !== 1'b0) begin n_bad++; $display("FAIL bp_second_rdata got=%h/%b required=56783344/0", bus.o_rsp_rdata, bus.o_rsp_err); end
    bus.i_rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.i_rsp_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_alias();
    logic [31:0] rd; logic er; int lt;
    do_txn(1'b1, 32'h80, 32'h12345678, 3'b010, rd, er, lt);
    do_txn(1'b0, 32'h00, 32'h0, 3'b010, rd, er, lt);
    n_cmp++; if (rd !== 32'h12345678 || er !== 1'b0) begin n_bad++; $display("FAIL alias_lw00 got=%h/%b required=12345678/0", rd, er); end
    do_txn(1'b0, 32'hFFFF_FF88, 32'h0, 3'b010, rd, er, lt);
    n_cmp++; if (rd !== 32'hDEAD7FEF || er !== 1'b0) begin n_bad++; $display("FAIL alias_lw_high got=%h/%b required=dead7fef/0", rd, er); end
  endtask

  task automatic test_reset_mid_store();
    logic [31:0] rd; logic er; int lt; int n;
    do_txn(1'b1, 32'h04, 32'h55555555, 3'b010, rd, er, lt);
    n = 0;
    while (bus.o_req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    bus.i_req_valid = 1'b1; bus.i_req_we = 1'b1; bus.i_req_addr = 32'h04;
    bus.i_req_wdata = 32'hAAAAAAAA; bus.i_req_funct3 = 3'b010;
    @(posedge clk);
    #1;
    bus.i_req_valid = 1'b0;
    // falling edge of cycle c+1: ACCESS (or first WAIT) is in progress
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (bus.o_req_ready !== 1'b0) begin n_bad++; $display("FAIL mid_rst_ready[%0d] got=%b required=0", i, bus.o_req_ready); end
      n_cmp++; if (bus.o_rsp_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_valid[%0d] got=%b required=0", i, bus.o_rsp_valid); end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (bus.o_rsp_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_no_rsp[%0d] got=%b required=0", i, bus.o_rsp_valid); end
      n_cmp++; if (bus.o_req_ready !== 1'b1) begin n_bad++; $display("FAIL mid_rst_idle[%0d] got=%b required=1", i, bus.o_req_ready); end
    end
    do_txn(1'b0, 32'h04, 32'h0, 3'b010, rd, er, lt);
    n_cmp++; if (rd !== 32'h55555555 || er !== 1'b0) begin n_bad++; $display("FAIL mid_rst_lw04 got=%h/%b required=55555555/0", rd, er); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_word_roundtrip();
    test_byte_lanes();
    test_errors();
    test_backpressure();
    test_alias();
    test_reset_mid_store();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the load/store unit of the RISC-V pipeline. It accepts one load or store request at a time over a valid/ready request channel and performs the access on a word-organised data RAM. It handles byte and halfword lanes, load sign and zero extension, and misalignment checks, then returns the result over a valid/ready response channel. It replaces the bare data memory behind the MEM stage and fixes the handshake that the future DDR3 controller interface will also follow.

## Interface
- DATA_WIDTH, 32, data word width (fixed at 32 for byte-lane logic)
- ADDR_WIDTH, 32, request address width
- MEM_DEPTH, 32, RAM depth in words (power of two)
- WAIT_CYCLES, 4, extra access latency in cycles, used only when DMEM_WAIT_STATES_EN is defined
- i_clk  in  1  clock
- i_reset_n  in  1  reset: synchronous, active-low; clock i_clk
- i_req_valid  in  1  request valid
- o_req_ready  out  1  responder can accept a request
- i_req_we  in  1  1 = store, 0 = load
- i_req_addr  in  ADDR_WIDTH  byte address
- i_req_wdata  in  DATA_WIDTH  store data, right-aligned (byte in [7:0], half in [15:0])
- i_req_funct3  in  3  RISC-V funct3 access size/sign
- o_rsp_valid  out  1  response valid
- i_rsp_ready  in  1  initiator accepts response
- o_rsp_rdata  out  DATA_WIDTH  load result, already extended; 0 for stores and errors
- o_rsp_err  out  1  misaligned or unsupported access

## Operation
- Word index: i_req_addr[$clog2(MEM_DEPTH)+1:2]. Byte offset: i_req_addr[1:0].
- Upper address bits are ignored, so addresses alias.
- funct3 values:
  - 000 LB/SB
  - 001 LH/SH
  - 010 LW/SW
  - 100 LBU
  - 101 LHU
- Error cases, which raise o_rsp_err=1 with no RAM write and rdata=0:
  - funct3 011, 110 or 111.
  - 100 or 101 with i_req_we=1.
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]!=0.
- Stores: write only the addressed lanes. A byte store writes lane addr[1:0]. A half store writes lanes {addr[1],0} and {addr[1],1}. Other lanes are preserved.
- Loads: extract the addressed lane(s). LB and LH sign-extend. LBU and LHU zero-extend.
- Request fields are latched on the request handshake and are not re-sampled afterwards.
- Every request gets exactly one response. Stores respond with rdata=0.
- FSM states:
  - IDLE: o_req_ready=1. On i_req_valid, latch the request and go to ACCESS, or to WAIT when the macro is defined and WAIT_CYCLES>0.
  - WAIT: count down WAIT_CYCLES, then go to ACCESS.
  - ACCESS: RAM read or write happens at the end of this cycle; go to RESP.
  - RESP: o_rsp_valid=1 with rdata and err stable. On i_rsp_ready, go to IDLE.
- o_req_ready=0 in WAIT, ACCESS and RESP. Only one transaction is ever outstanding.
- RAM contents are not cleared by reset.

## Timing
- All outputs are registered.
- Reset values: o_req_ready=0, o_rsp_valid=0, o_rsp_rdata=0, o_rsp_err=0, FSM in IDLE, wait counter 0.
- o_req_ready rises in the first cycle after i_reset_n is sampled high.
- Latency, with request handshake in cycle c:
  - Without the macro: ACCESS in c+1, o_rsp_valid=1 from c+2.
  - With the macro: WAIT in c+1..c+WAIT_CYCLES, ACCESS in c+WAIT_CYCLES+1, o_rsp_valid from c+WAIT_CYCLES+2.
- Response handshake in cycle r: o_rsp_valid=0 and o_req_ready=1 in r+1. A new request can be accepted in r+1, no earlier.
- Best-case throughput is one request per 3 cycles.
- Response backpressure: while RESP holds and i_rsp_ready=0, all o_rsp_* signals stay constant.
- Reset mid-operation: the FSM returns to IDLE and outputs go to reset values. A store is not committed if reset is sampled low on the ACCESS clock edge or earlier. The pending response is discarded.
- Erroring requests follow identical latency.

## Configuration
- DMEM_WAIT_STATES_EN defined: the WAIT state and a $clog2(WAIT_CYCLES+1)-bit down-counter are compiled in, and every access is stretched by WAIT_CYCLES cycles. This emulates DDR3 latency for stall testing. WAIT_CYCLES=0 gives timing identical to the undefined case.
- DMEM_WAIT_STATES_EN undefined: no WAIT state or counter exists, latency is fixed at 2 cycles to o_rsp_valid, and WAIT_CYCLES is ignored.

## Test plan
- Word round-trip:
  - SW addr 0x08 data 0xDEADBEEF, then LW addr 0x08 -> rsp rdata 0xDEADBEEF, err=0.
  - o_rsp_valid in cycle c+2 without macro and c+6 with macro at WAIT_CYCLES=4.
- Byte lanes and extension:
  - After the 0xDEADBEEF store, SB addr 0x09 data 0x7F.
  - Then LW 0x08 -> 0xDEAD7FEF; LB 0x0B -> 0xFFFFFFDE; LBU 0x0B -> 0x000000DE; LH 0x0A -> 0xFFFFDEAD; LHU 0x08 -> 0x00007FEF.
- Misalignment and illegal encodings:
  - LW 0x0A, SH 0x09 and funct3=011 -> err=1, rdata=0.
  - Subsequent LW 0x08 shows memory unchanged.
- Backpressure: hold i_rsp_ready=0 for 5 cycles in RESP -> rsp fields stable, o_req_ready=0, and a request presented meanwhile is not accepted until the cycle after the response handshake.
- Aliasing: SW addr 0x80 data 0x12345678 with MEM_DEPTH=32 -> LW 0x00 returns 0x12345678.
- Reset mid-store: SW 0x04 data 0xAAAAAAAA with reset asserted in WAIT/ACCESS -> no response, o_req_ready=0 during reset, and LW 0x04 afterwards returns the prior value.
